// File: rtl/native_mem_pkg.sv
// Shared encodings and helpers for the native memory master and future responders.
// Pure definitions: no state, no timing.
package native_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Size 3 is never aligned, so it falls out of this check as an error.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  is_aligned = 1'b1;
      SIZE_H:  is_aligned = ~off[0];
      SIZE_W:  is_aligned = (off == 2'd0);
      default: is_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  gen_wstrb = 4'b0001 << off;
      SIZE_H:  gen_wstrb = 4'b0011 << off;
      SIZE_W:  gen_wstrb = 4'b1111;
      default: gen_wstrb = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/native_mem_lanes.sv
// Byte-lane steering: replicate write data across lanes, extract and extend read data.
// Purely combinational; no handshake.
module native_mem_lanes
  import native_mem_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_off,
  input  logic        rd_signed,
  input  logic [31:0] rd_data,
  output logic [31:0] wr_rep,
  output logic [31:0] rd_ext
);

  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_shift = rd_data >> {rd_off, 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = rd_off[1] ? rd_data[31:16] : rd_data[15:0];

    case (wr_size)
      SIZE_B:  wr_rep = {4{wr_data[7:0]}};
      SIZE_H:  wr_rep = {2{wr_data[15:0]}};
      default: wr_rep = wr_data;
    endcase

    case (rd_size)
      SIZE_B:  rd_ext = {{24{rd_signed & rd_byte[7]}}, rd_byte};
      SIZE_H:  rd_ext = {{16{rd_signed & rd_half[15]}}, rd_half};
      default: rd_ext = rd_data;
    endcase
  end

endmodule

// File: rtl/native_mem_master.sv
// One-command-at-a-time initiator on the picorv32 native bus: cmd -> bus cycle -> rsp.
// Latency 2 cycles with a ready responder; cmd_ready low until the response is taken.
module native_mem_master
  import native_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_instr,
  input  logic [1:0]  cmd_size,
  input  logic        cmd_signed,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           req_size;
  logic [1:0]           req_off;
  logic                 req_signed;
  logic                 req_write;
  logic [31:0]          wdata_rep;
  logic [31:0]          rdata_ext;
  logic                 timeout_hit;

  assign cmd_ready   = resetn && (state == ST_IDLE);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // Write side steers the incoming command; read side uses the latched request.
  native_mem_lanes u_lanes (
    .wr_size   (cmd_size),
    .wr_data   (cmd_wdata),
    .rd_size   (req_size),
    .rd_off    (req_off),
    .rd_signed (req_signed),
    .rd_data   (mem_rdata),
    .wr_rep    (wdata_rep),
    .rd_ext    (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            req_size   <= cmd_size;
            req_off    <= cmd_addr[1:0];
            req_signed <= cmd_signed;
            req_write  <= cmd_write;
            if (!is_aligned(cmd_size, cmd_addr[1:0])) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
              state     <= ST_RESP;
            end else begin
              mem_valid <= 1'b1;
              mem_instr <= cmd_instr;
              mem_addr  <= {cmd_addr[31:2], 2'b00};
              mem_wdata <= wdata_rep;
              mem_wstrb <= cmd_write ? gen_wstrb(cmd_size, cmd_addr[1:0]) : 4'b0000;
              cnt       <= '0;
              state     <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          // A ready on the final count edge completes normally rather than timing out.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'b0000;
            mem_instr <= 1'b0;
            rsp_rdata <= req_write ? 32'h0 : rdata_ext;
            rsp_error <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (timeout_hit) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'b0000;
            mem_instr <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_native_mem_master.sv
// Directed bench for native_mem_master with a word-memory responder of configurable wait states.
// Expected values are hand-computed constants.
module tb_native_mem_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic        cmd_instr = 1'b0;
  logic [1:0]  cmd_size = 2'd0;
  logic        cmd_signed = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  native_mem_master #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_instr(cmd_instr), .cmd_size(cmd_size), .cmd_signed(cmd_signed),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Responder: 256-word memory, ready after wait_states stalled cycles unless stuck.
  logic [31:0] mem [0:255];
  int          wait_states = 0;
  logic        stuck = 1'b0;
  int          wcnt = 0;

  assign mem_ready = mem_valid && !stuck && (wcnt >= wait_states);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    wcnt <= (mem_valid && !mem_ready) ? wcnt + 1 : 0;
    if (mem_valid && mem_ready) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Results of the last transaction
  int          lat, mv, crb, unst, rv_drop;
  logic [31:0] cap_addr, cap_wdata, r_rdata;
  logic [3:0]  cap_wstrb;
  logic        cap_instr, r_error, post_rv, post_cr;

  task automatic run_cmd(input logic w, input logic ins, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input int rdy_hold);
    @(negedge clk);
    cmd_write = w; cmd_instr = ins; cmd_size = sz; cmd_signed = sg;
    cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; mv = 0; crb = 0; unst = 0; rv_drop = 0;
    cap_addr = 32'h0; cap_wdata = 32'h0; cap_wstrb = 4'h0; cap_instr = 1'b0;
    while (!rsp_valid && lat < 64) begin
      if (cmd_ready) crb++;
      if (mem_valid) begin
        if (mv == 0) begin
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb; cap_instr = mem_instr;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_wstrb !== cap_wstrb)
          unst++;
        mv++;
      end
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_wait_bound", 32'd0, 32'd1);
    r_rdata = rsp_rdata;
    r_error = rsp_error;
    for (int i = 0; i < rdy_hold; i++) begin
      @(negedge clk);
      if (!rsp_valid) rv_drop++;
      if (cmd_ready) crb++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    post_rv = rsp_valid;
    post_cr = cmd_ready;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_cmd_ready_low", {31'b0, cmd_ready}, 32'd0);
    check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    resetn = 1'b1;
    #1 check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Word write, always-ready memory
    run_cmd(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0);
    check("ww_mv_cycles", mv, 1);
    check("ww_addr", cap_addr, 32'h100);
    check("ww_wstrb", {28'b0, cap_wstrb}, 32'hF);
    check("ww_wdata", cap_wdata, 32'hDEADBEEF);
    check("ww_latency", lat, 2);
    check("ww_error", {31'b0, r_error}, 32'd0);
    check("ww_rdata", r_rdata, 32'd0);
    check("ww_post_rv", {31'b0, post_rv}, 32'd0);
    check("ww_post_cr", {31'b0, post_cr}, 32'd1);
    check("ww_mem", mem[8'h40], 32'hDEADBEEF);

    // Byte write to lane 3
    run_cmd(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0000005A, 0);
    check("bw_addr", cap_addr, 32'h100);
    check("bw_wstrb", {28'b0, cap_wstrb}, 32'h8);
    check("bw_wdata", cap_wdata, 32'h5A5A5A5A);
    check("bw_mem", mem[8'h40], 32'h5AADBEEF);
    run_cmd(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
    check("wr_rb_rdata", r_rdata, 32'h5AADBEEF);
    check("wr_rb_wstrb", {28'b0, cap_wstrb}, 32'h0);

    // Reads with extension, instruction flag passed through
    run_cmd(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h80011234, 0);
    run_cmd(1'b0, 1'b1, 2'd1, 1'b1, 32'h102, 32'h0, 0);
    check("rh_signed", r_rdata, 32'hFFFF8001);
    check("rh_instr", {31'b0, cap_instr}, 32'd1);
    run_cmd(1'b0, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0);
    check("rh_unsigned", r_rdata, 32'h00008001);
    run_cmd(1'b0, 1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 0);
    check("rb_signed_pos", r_rdata, 32'h00000034);
    run_cmd(1'b0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0);
    check("rb_signed_neg", r_rdata, 32'hFFFFFF80);
    run_cmd(1'b0, 1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 0);
    check("rh_low_half", r_rdata, 32'h00001234);

    // Alignment and size errors: no bus cycle
    run_cmd(1'b0, 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 0);
    check("mis_half_mv", mv, 0);
    check("mis_half_lat", lat, 1);
    check("mis_half_err", {31'b0, r_error}, 32'd1);
    check("mis_half_rdata", r_rdata, 32'd0);
    run_cmd(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h12345678, 0);
    check("mis_word_mv", mv, 0);
    check("mis_word_err", {31'b0, r_error}, 32'd1);
    check("mis_word_mem", mem[8'h40], 32'h80011234);
    run_cmd(1'b0, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0);
    check("size3_err", {31'b0, r_error}, 32'd1);
    check("size3_mv", mv, 0);

    // Wait states and a slow response consumer
    wait_states = 3;
    run_cmd(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 2);
    check("ws_mv_cycles", mv, 4);
    check("ws_stable", unst, 0);
    check("ws_rdata", r_rdata, 32'h80011234);
    check("ws_rv_held", rv_drop, 0);
    check("ws_cmd_ready_low", crb, 0);
    check("ws_post_cr", {31'b0, post_cr}, 32'd1);
    wait_states = 0;

    // Timeout with a dead responder
    stuck = 1'b1;
    run_cmd(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
    check("to_mv_cycles", mv, 8);
    check("to_err", {31'b0, r_error}, 32'd1);
    check("to_rdata", r_rdata, 32'd0);
    check("to_stable", unst, 0);

    // Reset while the bus cycle is pending
    @(negedge clk);
    cmd_write = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h100; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_mv_high", {31'b0, mem_valid}, 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_mv", {31'b0, mem_valid}, 32'd0);
    check("mid_rst_rv", {31'b0, rsp_valid}, 32'd0);
    resetn = 1'b1;
    stuck = 1'b0;
    #1 check("mid_rst_cr", {31'b0, cmd_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("mid_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Normal operation after the abandoned transaction
    run_cmd(1'b0, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 0);
    check("after_rst_rdata", r_rdata, 32'hFFFF8001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
